// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - instruction fetch initiator with output queue
//
// Purpose: issues word-aligned fetch addresses to a synchronous-read
// instruction memory, tracks the single in-flight read, queues returned
// words and hands {pc, instruction} to decode over valid/ready. Redirects
// flush both the queue and the in-flight read.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   imem_addr           fetch byte address (memory uses addr[31:2])
//   imem_rdata          read data, valid the cycle after imem_addr issued
//   redirect_valid/_pc  branch/jump taken this cycle and its target
//   inst_valid/_ready   head-of-queue handshake to decode
//   inst_data/_pc       head instruction word and its byte address
//   fetch_misaligned    sticky misaligned-redirect flag
//
// Optional feature: FETCH_MISALIGN_TRAP_EN. When defined, a redirect to a
// non-word-aligned target raises fetch_misaligned and stalls fetch until an
// aligned redirect arrives. When undefined, the low target bits are dropped
// and fetch_misaligned is tied low.

module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  output logic        fetch_misaligned
);

  localparam int         PW      = (DEPTH > 2) ? 2 : 1;
  localparam logic [3:0] DEPTH_W = 4'(DEPTH);

  logic [31:0]   pc_fetch;
  logic [31:0]   flight_pc;
  logic          inflight;
  logic [31:0]   q_pc   [DEPTH];
  logic [31:0]   q_data [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [2:0]    count;
  logic          misaligned;

  logic          fire;
  logic          push;
  logic          issue;
  logic [3:0]    demand;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // The memory re-reads pc_fetch every cycle; only issue decides whether the
  // returned word is kept.
  assign imem_addr  = pc_fetch;
  assign inst_valid = (count != 3'd0);
  assign inst_data  = q_data[head];
  assign inst_pc    = q_pc[head];

  assign fire = inst_valid & inst_ready;
  assign push = inflight & ~redirect_valid;

  // Slots already spoken for: queued words plus the word still in flight,
  // less the one leaving this cycle. Issue only if a slot remains, so the
  // queue can never overflow.
  assign demand = {1'b0, count} + {3'b000, inflight} - {3'b000, fire};
  assign issue  = ~redirect_valid & ~misaligned & (demand < DEPTH_W);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_fetch  <= RESET_PC;
      flight_pc <= '0;
      inflight  <= 1'b0;
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        q_pc[i]   <= '0;
        q_data[i] <= '0;
      end
    end else if (redirect_valid) begin
      // Flush wins over everything; a same-cycle fire has already been
      // consumed by decode, so dropping the head here loses nothing.
      pc_fetch <= {redirect_pc[31:2], 2'b00};
      inflight <= 1'b0;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
    end else begin
      inflight <= issue;
      if (issue) begin
        pc_fetch  <= pc_fetch + 32'd4;
        flight_pc <= pc_fetch;
      end
      if (push) begin
        q_pc[tail]   <= flight_pc;
        q_data[tail] <= imem_rdata;
        tail         <= ptr_inc(tail);
      end
      if (fire) begin
        head <= ptr_inc(head);
      end
      count <= count + {2'b00, push} - {2'b00, fire};
    end
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  // Sticky until the next redirect; only an aligned target clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misaligned <= 1'b0;
    end else if (redirect_valid) begin
      misaligned <= |redirect_pc[1:0];
    end
  end
`else
  logic unused_redirect_low;
  assign unused_redirect_low = ^redirect_pc[1:0];
  assign misaligned          = 1'b0;
`endif

  assign fetch_misaligned = misaligned;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - randomized self-checking bench for instr_fetch_unit

module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        fetch_misaligned;

  instr_fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .imem_addr        (imem_addr),
    .imem_rdata       (imem_rdata),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .inst_valid       (inst_valid),
    .inst_ready       (inst_ready),
    .inst_data        (inst_data),
    .inst_pc          (inst_pc),
    .fetch_misaligned (fetch_misaligned)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return 32'h0000_1000 + (a >> 2);
  endfunction

  // synchronous-read memory: word[i] = 0x1000 + i
  always @(posedge clk) imem_rdata <= word_of(imem_addr);

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // reference model: expected program-order stream of delivered pcs
  logic [31:0] exp_pc;
  int          since_redir;
  int          streak;
  int          delivered;
  bit          trapped;
  bit          prev_valid, prev_rdy, prev_rv;
  logic [31:0] prev_pc, prev_data;

  task automatic reset_model();
    exp_pc      = 32'h0;
    since_redir = 100;
    streak      = 0;
    trapped     = 1'b0;
    prev_valid  = 1'b0;
    prev_rdy    = 1'b0;
    prev_rv     = 1'b0;
  endtask

  // Called at a negedge: check visible state, drive this cycle's inputs,
  // advance the model, then move to the next negedge.
  task automatic step(input bit rdy, input bit rv, input logic [31:0] rpc);
    if (trapped) begin
      check("trap_valid", 32'(inst_valid), 32'd0);
      check("trap_flag", 32'(fetch_misaligned), 32'd1);
    end else begin
      check("flag_low", 32'(fetch_misaligned), 32'd0);
      if (since_redir == 1 || since_redir == 2)
        check("flush_gap", 32'(inst_valid), 32'd0);
      if (since_redir == 3)
        check("redir_latency", 32'(inst_valid), 32'd1);
      if (streak >= 3)
        check("throughput", 32'(inst_valid), 32'd1);
    end
    if (inst_valid)
      check("head_data", inst_data, word_of(inst_pc));
    if (prev_valid && !prev_rdy && !prev_rv) begin
      check("hold_pc", inst_pc, prev_pc);
      check("hold_data", inst_data, prev_data);
    end

    inst_ready     = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;

    if (inst_valid && rdy) begin
      check("order_pc", inst_pc, exp_pc);
      exp_pc = exp_pc + 32'd4;
      delivered++;
    end
    if (rv) begin
`ifdef FETCH_MISALIGN_TRAP_EN
      trapped = (rpc[1:0] != 2'b00);
`endif
      exp_pc      = {rpc[31:2], 2'b00};
      since_redir = 0;
      streak      = 0;
    end else begin
      streak = rdy ? streak + 1 : 0;
    end
    prev_valid = inst_valid;
    prev_rdy   = rdy;
    prev_rv    = rv;
    prev_pc    = inst_pc;
    prev_data  = inst_data;

    @(posedge clk);
    @(negedge clk);
    if (since_redir < 100) since_redir++;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, 32'(inst_valid), 32'd0);
    check({tag, "_data"}, inst_data, 32'd0);
    check({tag, "_pc"}, inst_pc, 32'd0);
    check({tag, "_addr"}, imem_addr, 32'h0);
    check({tag, "_flag"}, 32'(fetch_misaligned), 32'd0);
  endtask

  initial begin
    logic [31:0] rpc;
    bit          rdy, rv;
    int          guard;

    rst_n          = 1'b0;
    inst_ready     = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    delivered      = 0;
    reset_model();
    #2;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // first word latency
    step(1, 0, 0);
    check("first_lat0", 32'(inst_valid), 32'd0);
    step(1, 0, 0);
    check("first_valid", 32'(inst_valid), 32'd1);
    check("first_pc", inst_pc, 32'h0);
    check("first_data", inst_data, 32'h1000);
    for (int i = 0; i < 6; i++) step(1, 0, 0);

    // stall then release
    for (int i = 0; i < 5; i++) step(0, 0, 0);
    for (int i = 0; i < 6; i++) step(1, 0, 0);

    // redirect while streaming
    step(1, 1, 32'h40);
    step(1, 0, 0);
    step(1, 0, 0);
    check("redir40_valid", 32'(inst_valid), 32'd1);
    check("redir40_pc", inst_pc, 32'h40);
    check("redir40_data", inst_data, 32'h1010);
    for (int i = 0; i < 4; i++) step(1, 0, 0);

    // redirect while stalled with a full queue
    for (int i = 0; i < 4; i++) step(0, 0, 0);
    step(0, 1, 32'h200);
    for (int i = 0; i < 5; i++) step(1, 0, 0);

    // back-to-back redirects
    step(1, 1, 32'h80);
    step(1, 1, 32'h100);
    step(1, 0, 0);
    step(0, 0, 0);
    check("b2b_pc", inst_pc, 32'h100);
    check("b2b_valid", 32'(inst_valid), 32'd1);
    for (int i = 0; i < 4; i++) step(1, 0, 0);

    // address wrap
    step(1, 1, 32'hFFFF_FFF8);
    for (int i = 0; i < 7; i++) step(1, 0, 0);

    // misaligned redirect
    step(1, 1, 32'h42);
    step(1, 0, 0);
    step(0, 0, 0);
`ifdef FETCH_MISALIGN_TRAP_EN
    check("mis_flag", 32'(fetch_misaligned), 32'd1);
    check("mis_valid", 32'(inst_valid), 32'd0);
    for (int i = 0; i < 3; i++) step(1, 0, 0);
    step(1, 1, 32'h44);
    step(1, 0, 0);
    step(0, 0, 0);
    check("mis_clear", 32'(fetch_misaligned), 32'd0);
    check("mis_pc", inst_pc, 32'h44);
`else
    check("mis_pc", inst_pc, 32'h40);
    check("mis_flag", 32'(fetch_misaligned), 32'd0);
`endif
    for (int i = 0; i < 4; i++) step(1, 0, 0);

    // mid-stream asynchronous reset
    step(1, 1, 32'h0);
    guard = 0;
    while (!(inst_valid && inst_pc == 32'h20) && guard < 40) begin
      step(1, 0, 0);
      guard++;
    end
    check("reach_0x20", 32'(guard < 40), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    @(negedge clk);
    check_reset_outputs("held_rst");
    rst_n = 1'b1;
    reset_model();
    step(1, 0, 0);
    step(1, 0, 0);
    check("restart_pc", inst_pc, 32'h0);
    check("restart_valid", 32'(inst_valid), 32'd1);

    // randomized traffic
    delivered = 0;
    for (int i = 0; i < 600; i++) begin
      rdy = ($urandom_range(0, 3) != 0);
      rv  = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 7) == 0)
        rpc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      else if ($urandom_range(0, 3) == 0)
        rpc = 32'($urandom_range(0, 1023));
      else
        rpc = 32'($urandom_range(0, 255)) << 2;
      step(rdy, rv, rpc);
    end
    // clear any trap and drain with ready high
    step(1, 1, 32'h300);
    for (int i = 0; i < 10; i++) step(1, 0, 0);
    check("progress", 32'(delivered > 100), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
